regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Controller for the register file's single write port. Arbitrates up to NUM_REQ writeback sources (ALU, load unit, CSR/mul) onto the file's writeReg/writeData/write inputs using round-robin. Also keeps a 32-bit pending-write scoreboard that the issue stage sets and queries for RAW hazards. Sits between the execute/memory writeback paths and the register file.

Parameters:
DATAWIDTH, 32, width of the write data, matching the register file.
NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-source writeback request
req_ready  output  NUM_REQ  per-source grant; a handshake occurs when valid and ready are both high
req_addr  input  5*NUM_REQ  flat-packed destination register; source i uses bits [5i+4:5i]
req_data  input  DATAWIDTH*NUM_REQ  flat-packed write data per source
writeReg  output  5  to register file writeReg
writeData  output  DATAWIDTH  to register file writeData
write  output  1  to register file write enable
sb_set  input  1  issue stage marks a destination as pending
sb_set_addr  input  5  destination being marked
rs1  input  5  hazard query address 1
rs2  input  5  hazard query address 2
hazard1  output  1  rs1 has a pending write
hazard2  output  1  rs2 has a pending write
busy  output  32  scoreboard bit vector, for debug

Behaviour:
- Reset (async, rst_n=0): write=0, writeReg=0, writeData=0, busy=0, rr_ptr=0. Reset mid-transfer drops any grant in flight; all state clears immediately.
- Arbitration is combinational within a cycle:
  - Scan sources starting at rr_ptr, wrapping modulo NUM_REQ. The first source with req_valid=1 wins.
  - req_ready is one-hot on the winner and all zeros when no source is valid.
  - req_ready never depends on the ready state of any other source.
- Round-robin pointer: on a handshake, rr_ptr becomes (winner+1) mod NUM_REQ at the next edge. With no handshake, rr_ptr holds.
- Output register, 1-cycle latency:
  - On the edge following a handshake with addr≠0: write=1, writeReg=req_addr[winner], writeData=req_data[winner].
  - Otherwise write=0, and writeReg/writeData hold their last values.
  - write is high for exactly one cycle per accepted non-x0 request.
- x0 writes: a request with addr=0 is accepted (ready=1, handshake consumed, rr_ptr advances), but write stays 0 and the scoreboard is untouched.
- A source holding valid with no grant must keep addr and data stable. The arbiter never drops a valid request; the worst-case wait is NUM_REQ-1 grants.
- Scoreboard, busy[31:0]:
  - sb_set=1 with sb_set_addr≠0 sets busy[sb_set_addr] at the next edge.
  - A handshake with addr≠0 clears busy[addr] at the same edge where write rises.
  - If set and clear hit the same address in the same cycle, set wins and the bit stays 1 (a new producer was issued).
  - sb_set with addr 0 is ignored. busy[0] is always 0.
  - A clear for an address that is not busy is harmless.
- Hazard outputs are combinational: hazard1 = busy[rs1], hazard2 = busy[rs2]. Because busy[0] is always 0, x0 queries never hazard.
  - The register file writes combinationally while write=1, so the hazard deasserts in the same cycle the new value becomes readable.
- Back-to-back operation: one write per cycle is sustained while any request is valid; there are no bubbles between grants.

Test Plan:
- Reset: hold rst_n=0 mid-stream with req_valid=3'b111 → write=0, busy=0, req_ready still computed from rr_ptr=0 (ready=3'b001). After release, first grant goes to source 0.
- Round-robin: req_valid=3'b111 held for 6 cycles, addrs 5/6/7, data A/B/C → grants 0,1,2,0,1,2. write=1 on every cycle from cycle 2; writeReg sequence 5,6,7,5,6,7.
- Single source plus x0: source 1 sends addr=0 data=0xDEAD, then addr=9 data=0x1234 → ready both cycles; write=0 then write=1, writeReg=9, writeData=0x1234.
- Scoreboard: sb_set addr=12, then query rs1=12 → hazard1=1. Source 2 writes addr 12 → hazard1=0 in the cycle write=1, and busy[12]=0.
- Set/clear collision: busy[4]=1, then in the same cycle sb_set addr=4 and source 0 writes addr 4 → write=1 with writeReg=4, and busy[4] remains 1.
- Fairness: source 0 valid continuously, source 2 raises valid at cycle 3 → source 2 is granted within 2 cycles. Source 0 never receives two grants in a row while source 2 waits.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the writeback sources and the register-file write port.
// The sources drive the request side, and the arbiter drives the grants and the write-port outputs.
interface regfile_wb_arbiter_if #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REQ   = 3
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [5*NUM_REQ-1:0]         req_addr;
  logic [DATAWIDTH*NUM_REQ-1:0] req_data;
  logic [4:0]                   writeReg;
  logic [DATAWIDTH-1:0]         writeData;
  logic                         write;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, writeReg, writeData, write
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, writeReg, writeData, write
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port, with a pending-write scoreboard.
// The issue stage uses the scoreboard to detect RAW hazards.
module regfile_wb_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NUM_REQ   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus,
  input  logic                 sb_set,
  input  logic [4:0]           sb_set_addr,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 hazard1,
  output logic                 hazard2,
  output logic [31:0]          busy
);

  localparam int              PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0]   NREQ = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 r_write;
  logic [4:0]           r_wreg;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [31:0]          r_busy;

  logic [PTR_W-1:0]     w_winner;
  logic                 w_found;
  logic [PTR_W:0]       w_idx;
  logic [NUM_REQ-1:0]   w_ready;
  logic [4:0]           w_addr_arr [NUM_REQ];
  logic [DATAWIDTH-1:0] w_data_arr [NUM_REQ];
  logic [4:0]           w_win_addr;
  logic [DATAWIDTH-1:0] w_win_data;
  logic                 w_wr;
  logic [31:0]          w_busy_nxt;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr_arr[g] = bus.req_addr[5*g +: 5];
      assign w_data_arr[g] = bus.req_data[DATAWIDTH*g +: DATAWIDTH];
    end
  endgenerate

  // Scan from rr_ptr with modulo wrap; the first valid source wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && bus.req_valid[w_idx[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_found) w_ready[w_winner] = 1'b1;
  end

  assign w_win_addr = w_addr_arr[w_winner];
  assign w_win_data = w_data_arr[w_winner];
  // Writes to x0 are still handshaken, but they never reach the register file or the scoreboard.
  assign w_wr       = w_found && (w_win_addr != 5'd0);

  // On a same-address collision, the set wins because a newer producer has already been issued.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr) w_busy_nxt[w_win_addr] = 1'b0;
    if (sb_set && (sb_set_addr != 5'd0)) w_busy_nxt[sb_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_write  <= 1'b0;
      r_wreg   <= 5'd0;
      r_wdata  <= '0;
      r_busy   <= 32'd0;
    end else begin
      if (w_found) r_rr_ptr <= (w_winner == LAST) ? '0 : w_winner + PTR_W'(1);
      r_write <= w_wr;
      if (w_wr) begin
        r_wreg  <= w_win_addr;
        r_wdata <= w_win_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.write     = r_write;
  assign bus.writeReg  = r_wreg;
  assign bus.writeData = r_wdata;
  assign busy          = r_busy;
  assign hazard1       = r_busy[rs1];
  assign hazard2       = r_busy[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter.
// A queue-based reference model predicts each write, and a separate monitor checks every write.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATAWIDTH(DW), .NUM_REQ(NR)) bus ();

  logic        sb_set = 1'b0;
  logic [4:0]  sb_set_addr = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic        hazard1, hazard2;
  logic [31:0] busy;

  regfile_wb_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .busy        (busy)
  );

  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            m_rr = 0;
  logic [31:0]   m_busy = 32'd0;
  logic [4:0]    m_wreg = 5'd0;
  logic [DW-1:0] m_wdata = '0;
  int            last_win = -1;

  logic [NR-1:0] s_valid;
  logic [4:0]    s_addr [NR];
  logic [DW-1:0] s_data [NR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic apply();
    bus.req_valid = s_valid;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[5*i +: 5]    = s_addr[i];
      bus.req_data[DW*i +: DW]  = s_data[i];
    end
  endtask

  task automatic clear_stim();
    s_valid = '0;
    for (int i = 0; i < NR; i++) begin
      s_addr[i] = 5'd0;
      s_data[i] = '0;
    end
    sb_set = 1'b0;
    sb_set_addr = 5'd0;
  endtask

  // Called when rst_n falls: every in-flight grant and pending bit is lost.
  task automatic model_reset();
    q.delete();
    m_rr    = 0;
    m_busy  = 32'd0;
    m_wreg  = 5'd0;
    m_wdata = '0;
  endtask

  // Drive one cycle: check the combinational and state outputs, then advance the model.
  task automatic step();
    int w;
    int idx;
    logic [NR-1:0] er;
    apply();
    @(negedge clk);
    w = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_rr + k) % NR;
      if (w < 0 && s_valid[idx]) w = idx;
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    chk("busy", busy, m_busy);
    chk("hazard1", hazard1, m_busy[rs1]);
    chk("hazard2", hazard2, m_busy[rs2]);
    if (!rst_n) begin
      chk("write_in_reset", bus.write, 1'b0);
      last_win = -1;
    end else begin
      last_win = w;
      if (w >= 0) begin
        if (s_addr[w] != 5'd0) begin
          q.push_back('{a: s_addr[w], d: s_data[w], c: cyc + 1});
          m_busy[s_addr[w]] = 1'b0;
        end
        m_rr = (w + 1) % NR;
      end
      if (sb_set && sb_set_addr != 5'd0) m_busy[sb_set_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: each expected write must appear in exactly its predicted cycle; otherwise the port must stay idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        chk("write", bus.write, 1'b1);
        chk("writeReg", bus.writeReg, e.a);
        chk("writeData", bus.writeData, e.d);
        m_wreg  = e.a;
        m_wdata = e.d;
      end else begin
        chk("write_idle", bus.write, 1'b0);
        chk("writeReg_hold", bus.writeReg, m_wreg);
        chk("writeData_hold", bus.writeData, m_wdata);
      end
    end
  end

  initial begin
    int wins[$];
    int first2;
    int viol;
    clear_stim();
    apply();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset with every source requesting.
    s_valid = 3'b111;
    s_addr[0] = 5'd5;  s_addr[1] = 5'd6;  s_addr[2] = 5'd7;
    s_data[0] = 32'hAAAA_0001; s_data[1] = 32'hBBBB_0002; s_data[2] = 32'hCCCC_0003;
    step();
    step();
    rst_n = 1'b1;

    // Round robin across three persistent requesters.
    wins.delete();
    for (int k = 0; k < 6; k++) begin
      step();
      wins.push_back(last_win);
    end
    for (int k = 0; k < 6; k++) chk("rr_order", wins[k], k % NR);
    clear_stim();
    step();

    // An x0 request is consumed but produces no write.
    s_valid = 3'b010; s_addr[1] = 5'd0; s_data[1] = 32'h0000_DEAD;
    step();
    s_addr[1] = 5'd9; s_data[1] = 32'h0000_1234;
    step();
    clear_stim();
    step();
    chk("x0_then_writeReg", bus.writeReg, 5'd9);
    chk("x0_then_writeData", bus.writeData, 32'h0000_1234);

    // Scoreboard set, then a hazard query, then a clear by writeback.
    sb_set = 1'b1; sb_set_addr = 5'd12;
    step();
    sb_set = 1'b0; rs1 = 5'd12;
    step();
    s_valid = 3'b100; s_addr[2] = 5'd12; s_data[2] = 32'h1212_1212;
    step();
    clear_stim();
    step();
    chk("busy12_cleared", busy[12], 1'b0);

    // A set and a clear on the same address in one cycle.
    sb_set = 1'b1; sb_set_addr = 5'd4; rs2 = 5'd4;
    step();
    s_valid = 3'b001; s_addr[0] = 5'd4; s_data[0] = 32'h4444_4444;
    step();
    clear_stim();
    step();
    chk("collision_busy4", busy[4], 1'b1);

    // Fairness: source 0 requests continuously, and source 2 joins at the third step.
    wins.delete();
    viol = 0;
    s_valid = 3'b001; s_addr[0] = 5'd1; s_data[0] = 32'h0101_0101;
    s_addr[2] = 5'd3; s_data[2] = 32'h0303_0303;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) s_valid[2] = 1'b1;
      step();
      wins.push_back(last_win);
      if (last_win == 2) s_valid[2] = 1'b0;
    end
    first2 = -1;
    for (int k = 3; k < 8; k++) begin
      if (first2 < 0 && wins[k] == 2) first2 = k;
      if (first2 < 0 && k > 3 && wins[k] == 0 && wins[k-1] == 0) viol++;
    end
    chk("fair_src2_granted", (first2 >= 3 && first2 - 3 <= 2), 1'b1);
    chk("fair_no_double_src0", viol, 0);
    clear_stim();
    step();

    // A reset mid-stream drops the grant in flight.
    s_valid = 3'b111;
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Random traffic. A source that is not granted keeps its request unchanged.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(s_valid[i] && last_win != i)) begin
          s_valid[i] = ($urandom_range(0, 3) != 0);
          s_addr[i]  = 5'($urandom_range(0, 7));
          s_data[i]  = DW'($urandom);
        end
      end
      sb_set      = ($urandom_range(0, 2) == 0);
      sb_set_addr = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      step();
    end

    clear_stim();
    for (int k = 0; k < 3; k++) step();
    chk("drain_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d limit=20000", cyc);
    $fatal(1);
  end
endmodule
